// File: rtl/rv32_ctrl_pkg.sv
// rv32_ctrl_pkg: shared state, opcode, class and select encodings for the multi-cycle controller
package rv32_ctrl_pkg;
  typedef logic [2:0] state_t;
  localparam state_t S_FETCH  = 3'd0;
  localparam state_t S_DECODE = 3'd1;
  localparam state_t S_EXEC   = 3'd2;
  localparam state_t S_MEM    = 3'd3;
  localparam state_t S_WB     = 3'd4;
  localparam state_t S_TRAP   = 3'd5;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [2:0] IMM_I = 3'd0;
  localparam logic [2:0] IMM_S = 3'd1;
  localparam logic [2:0] IMM_B = 3'd2;
  localparam logic [2:0] IMM_J = 3'd3;
  localparam logic [2:0] IMM_U = 3'd7;
  localparam logic [3:0] ALU_ADD   = 4'd0;
  localparam logic [3:0] ALU_SUB   = 4'd1;
  localparam logic [3:0] ALU_SLL   = 4'd2;
  localparam logic [3:0] ALU_SLT   = 4'd3;
  localparam logic [3:0] ALU_SLTU  = 4'd4;
  localparam logic [3:0] ALU_XOR   = 4'd5;
  localparam logic [3:0] ALU_SRL   = 4'd6;
  localparam logic [3:0] ALU_SRA   = 4'd7;
  localparam logic [3:0] ALU_OR    = 4'd8;
  localparam logic [3:0] ALU_AND   = 4'd9;
  localparam logic [3:0] ALU_PASSB = 4'd11;
  localparam logic [1:0] WB_MEM = 2'd0;
  localparam logic [1:0] WB_ALU = 2'd1;
  localparam logic [1:0] WB_PC4 = 2'd2;
  typedef enum logic [3:0] {
    CL_ALU_R, CL_ALU_I, CL_LUI, CL_AUIPC, CL_LOAD, CL_STORE, CL_BRANCH, CL_JAL, CL_JALR
  } cls_t;
  typedef struct packed {
    logic       mem_req;
    logic       mem_rw;
    logic       addr_sel;
    logic       ir_we;
    logic       pc_we;
    logic       pc_sel;
    logic [2:0] imm_sel;
    logic       reg_wen;
    logic       br_un;
    logic       a_sel;
    logic       b_sel;
    logic [3:0] alu_sel;
    logic [1:0] wb_sel;
    logic       illegal;
  } ctrl_t;
  function automatic logic [3:0] alu_op(input logic [2:0] f3, input logic alt);
    case (f3)
      3'd0:    return alt ? ALU_SUB : ALU_ADD;
      3'd1:    return ALU_SLL;
      3'd2:    return ALU_SLT;
      3'd3:    return ALU_SLTU;
      3'd4:    return ALU_XOR;
      3'd5:    return alt ? ALU_SRA : ALU_SRL;
      3'd6:    return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction
endpackage

// File: rtl/rv32_ctrl_decode.sv
// rv32_ctrl_decode: combinational map of the instruction word to class, selects and legality
module rv32_ctrl_decode
  import rv32_ctrl_pkg::*;
(
  input  logic [31:0] instr,
  output cls_t        cls,
  output logic [2:0]  imm_sel,
  output logic [3:0]  alu_sel,
  output logic        br_un,
  output logic        legal
);
  logic [6:0] op, f7;
  logic [2:0] f3;
  logic       unused_ok;
  assign op = instr[6:0];
  assign f3 = instr[14:12];
  assign f7 = instr[31:25];
  assign unused_ok = ^{instr[24:15], instr[11:7]};
  always_comb begin
    cls     = CL_ALU_R;
    imm_sel = IMM_I;
    alu_sel = ALU_ADD;
    legal   = 1'b0;
    br_un   = op == OP_BRANCH && f3[2:1] == 2'b11;
    case (op)
      OP_R: begin
        alu_sel = alu_op(f3, f7[5]);
        legal   = f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5));
      end
      OP_I: begin
        cls     = CL_ALU_I;
        alu_sel = alu_op(f3, f3 == 3'd5 && f7[5]);
        legal   = f3 == 3'd1 ? f7 == 7'h00 : f3 == 3'd5 ? (f7 == 7'h00 || f7 == 7'h20) : 1'b1;
      end
      OP_LOAD:   begin cls = CL_LOAD;   legal = f3 == 3'd2; end
      OP_STORE:  begin cls = CL_STORE;  imm_sel = IMM_S; legal = f3 == 3'd2; end
      OP_BRANCH: begin cls = CL_BRANCH; imm_sel = IMM_B; legal = f3[2:1] != 2'b01; end
      OP_JAL:    begin cls = CL_JAL;    imm_sel = IMM_J; legal = 1'b1; end
      OP_JALR:   begin cls = CL_JALR;   legal = f3 == 3'd0; end
      OP_LUI:    begin cls = CL_LUI;    imm_sel = IMM_U; alu_sel = ALU_PASSB; legal = 1'b1; end
      OP_AUIPC:  begin cls = CL_AUIPC;  imm_sel = IMM_U; legal = 1'b1; end
      default:   legal = 1'b0;
    endcase
  end
endmodule

// File: rtl/rv32_mc_ctrl.sv
// rv32_mc_ctrl: multi-cycle RV32I control FSM sharing one memory port for fetch and data.
// Performance counters are built only when RV32_MC_PERF_EN is defined.
module rv32_mc_ctrl
  import rv32_ctrl_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [31:0]      instr,
  input  logic             breq,
  input  logic             brlt,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_rw,
  output logic             addr_sel,
  output logic             ir_we,
  output logic             pc_we,
  output logic             pc_sel,
  output logic [2:0]       imm_sel,
  output logic             reg_wen,
  output logic             br_un,
  output logic             a_sel,
  output logic             b_sel,
  output logic [3:0]       alu_sel,
  output logic [1:0]       wb_sel,
  output logic             illegal,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instret_cnt
);
  state_t     state_q, state_d;
  cls_t       cls;
  logic [2:0] dec_imm;
  logic [3:0] dec_alu;
  logic       dec_br_un, legal, taken, is_br, is_ld, is_st, is_jmp;
  ctrl_t      c, o;
  rv32_ctrl_decode u_decode (
    .instr   (instr),
    .cls     (cls),
    .imm_sel (dec_imm),
    .alu_sel (dec_alu),
    .br_un   (dec_br_un),
    .legal   (legal)
  );
  assign is_br  = cls == CL_BRANCH;
  assign is_ld  = cls == CL_LOAD;
  assign is_st  = cls == CL_STORE;
  assign is_jmp = cls == CL_JAL || cls == CL_JALR;
  // funct3[2] picks lt vs eq, funct3[0] inverts the sense (BNE/BGE/BGEU)
  assign taken  = (instr[14] ? brlt : breq) ^ instr[12];
  always_comb begin
    c       = '0;
    state_d = state_q;
    case (state_q)
      S_FETCH: begin
        c.mem_req = 1'b1;
        c.ir_we   = mem_ready;
        state_d   = mem_ready ? S_DECODE : S_FETCH;
      end
      S_DECODE: state_d = legal ? S_EXEC : S_TRAP;
      S_EXEC: begin
        c.imm_sel = dec_imm;
        c.alu_sel = dec_alu;
        c.a_sel   = cls inside {CL_AUIPC, CL_JAL, CL_BRANCH};
        c.b_sel   = cls != CL_ALU_R;
        c.br_un   = dec_br_un;
        c.pc_we   = is_br;
        c.pc_sel  = is_br && taken;
        state_d   = is_br ? S_FETCH : (is_ld || is_st) ? S_MEM : S_WB;
      end
      S_MEM: begin
        c.mem_req  = 1'b1;
        c.addr_sel = 1'b1;
        c.mem_rw   = is_st;
        c.pc_we    = is_st && mem_ready;
        state_d    = !mem_ready ? S_MEM : is_st ? S_FETCH : S_WB;
      end
      S_WB: begin
        c.reg_wen = 1'b1;
        c.pc_we   = 1'b1;
        c.pc_sel  = is_jmp;
        c.wb_sel  = is_ld ? WB_MEM : is_jmp ? WB_PC4 : WB_ALU;
        state_d   = S_FETCH;
      end
      S_TRAP:  c.illegal = 1'b1;
      default: state_d = S_FETCH;
    endcase
  end
  assign o = rst_n ? c : '0;
  assign {mem_req, mem_rw, addr_sel, ir_we, pc_we, pc_sel, imm_sel, reg_wen,
          br_un, a_sel, b_sel, alu_sel, wb_sel, illegal} = o;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state_q <= S_FETCH;
    else        state_q <= state_d;
`ifdef RV32_MC_PERF_EN
  logic [CNT_W-1:0] cycle_q, cycle_d, instret_q, instret_d;
  always_comb begin
    cycle_d   = cycle_q + CNT_W'(1);
    instret_d = instret_q + CNT_W'(o.pc_we);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cycle_q   <= '0;
      instret_q <= '0;
    end else begin
      cycle_q   <= cycle_d;
      instret_q <= instret_d;
    end
  assign cycle_cnt   = cycle_q;
  assign instret_cnt = instret_q;
`else
  assign cycle_cnt   = '0;
  assign instret_cnt = '0;
`endif
endmodule

// File: doc/rv32_mc_ctrl.md
# rv32_mc_ctrl

Multi-cycle control sequencer for the RV32I core. It replaces one-shot combinational decode with a state machine, so one shared memory port serves both instruction fetch and data access. It reads the latched instruction register and the branch comparator flags, and drives the datapath enables, mux selects and memory handshake one phase per cycle. It sits between the instruction register/branch comparator and the PC, register-file, ALU and memory-port control inputs.

## Interface
- `CNT_W`, default 32: width of the performance counters.
- `clk` in 1: clock, rising edge.
- `rst_n` in 1: reset, asynchronous, active-low. One clock; no other clock domain.
- `instr` in 32: instruction register contents, stable from DECODE onward.
- `breq`, `brlt` in 1 each: branch comparator flags, valid in EXEC.
- `mem_ready` in 1: memory completes the current request this cycle.
- `mem_req` out 1: memory request.
- `mem_rw` out 1: memory direction, 1 = write.
- `addr_sel` out 1: memory address select, 0 = PC, 1 = ALU result register.
- `ir_we` out 1: instruction register load enable.
- `pc_we` out 1: PC write enable.
- `pc_sel` out 1: PC source, 0 = PC+4, 1 = ALU result.
- `imm_sel` out 3: immediate format, I=0, S=1, B=2, J=3, U=7.
- `reg_wen` out 1: register-file write enable.
- `br_un` out 1: unsigned branch compare.
- `a_sel` out 1: ALU A operand, 0 = rs1, 1 = PC.
- `b_sel` out 1: ALU B operand, 0 = rs2, 1 = immediate.
- `alu_sel` out 4: ALU operation, ADD0 SUB1 SLL2 SLT3 SLTU4 XOR5 SRL6 SRA7 OR8 AND9 PASSB11.
- `wb_sel` out 2: writeback source, 0 = memory, 1 = ALU, 2 = PC+4.
- `illegal` out 1: sticky illegal-instruction flag.
- `cycle_cnt`, `instret_cnt` out CNT_W each: performance counters.

## Operation
- States: FETCH, DECODE, EXEC, MEM, WB, TRAP. Reset state is FETCH.
- Control outputs are combinational from the state and `instr`.
- In every state, any output not listed below is 0.
- While `rst_n` is low, all outputs are 0.
- The datapath registers the ALU result every cycle and the memory read data on `mem_ready`.
- FETCH:
  - Drives `mem_req`=1, `addr_sel`=0, `mem_rw`=0.
  - `ir_we` = `mem_ready`. On `mem_ready` → DECODE; otherwise stay.
- DECODE:
  - Register read only; no write enables asserted.
  - Unknown opcode, or invalid funct3/funct7 (including SLLI/SRLI/SRAI funct7) → TRAP.
  - Otherwise → EXEC.
- EXEC, by instruction class:
  - ALU-R/ALU-I/LUI/AUIPC: drive operand and ALU selects, then → WB.
  - LW/SW: ADD with `b_sel`=1, then → MEM.
  - JAL: `a_sel`=1. JALR: `a_sel`=0. Both use ADD and → WB.
  - Branch:
    - Drives `imm_sel`=2, `a_sel`=1, `b_sel`=1, ADD, and `br_un` for BLTU/BGEU.
    - Taken is evaluated from `breq`/`brlt` per funct3.
    - Asserts `pc_we`=1 with `pc_sel`=taken, then → FETCH.
- MEM:
  - Drives `mem_req`=1, `addr_sel`=1, `mem_rw`=1 for SW.
  - Stays until `mem_ready`.
  - On `mem_ready`: LW → WB; SW → assert `pc_we`, `pc_sel`=0, → FETCH.
- WB:
  - Asserts `reg_wen`=1 and `pc_we`=1, then → FETCH.
  - `pc_sel`=1 for JAL/JALR, otherwise 0.
  - `wb_sel`: LW → 0, JAL/JALR → 2, otherwise 1.
- TRAP:
  - `illegal`=1; all enables 0.
  - Held until reset; no exit.
- An instruction retires in the cycle that `pc_we` is asserted.
- Instructions writing x0 still assert `reg_wen`; the register file discards the write.

## Timing
- `mem_req`, `addr_sel` and `mem_rw` are held stable until the cycle `mem_ready`=1.
- `mem_ready` outside FETCH/MEM is ignored.
- Cycle counts with zero-wait memory (`mem_ready` in the same cycle as `mem_req`):
  - ALU, LUI, AUIPC, JAL, JALR, SW: 4 cycles.
  - LW: 5 cycles.
  - Branch: 3 cycles.
- Each wait cycle in FETCH or MEM adds one cycle.
- Reset mid-operation: the state returns to FETCH asynchronously. No partial PC or register write completes, and `illegal` clears.

## Configuration
- With `RV32_MC_PERF_EN` defined:
  - `cycle_cnt` increments every cycle when not in reset.
  - `instret_cnt` increments on each retire.
  - Both counters wrap modulo 2^CNT_W and reset to 0.
- Without the macro: both counter outputs are constant 0 and no counter registers are built.

## Structure
- Shared package `rv32_ctrl_pkg` holds:
  - the state enum;
  - opcode constants (R 0110011, I 0010011, LOAD 0000011, STORE 0100011, BRANCH 1100011, JAL 1101111, JALR 1100111, LUI 0110111, AUIPC 0010111);
  - the `imm_sel`, `alu_sel` and `wb_sel` encodings.
- Sub-module `rv32_ctrl_decode`: purely combinational. It maps `instr` to class, `imm_sel`, `alu_sel`, `br_un` and legal.
- The top level holds the FSM, the per-state output gating and the counters.

## Test plan
- ADD x3,x1,x2 (0x002081B3), zero-wait memory:
  - `ir_we` in cycle 0, ALU selects `alu_sel`=0 in cycle 2;
  - `reg_wen`=1, `wb_sel`=1, `pc_we`=1 in cycle 3; back to FETCH in cycle 4.
- LW x5,8(x1) (0x0080A283), `mem_ready` delayed 2 cycles in MEM:
  - `mem_req`/`addr_sel`=1 held 3 cycles;
  - WB with `wb_sel`=0; 7 cycles total.
- BEQ with `breq`=1 (0x00208463): `pc_we`=1, `pc_sel`=1 in EXEC (cycle 2). With `breq`=0: `pc_sel`=0. No `reg_wen` in either case.
- BLTU (0x0020E463) with `brlt`=0: `br_un`=1, `pc_sel`=0.
- Instruction 0x00000000:
  - TRAP after DECODE, `illegal`=1, no further `mem_req`;
  - a `rst_n` pulse clears `illegal` and resumes FETCH.
- `rst_n` asserted during MEM of SW:
  - all outputs 0 immediately, no `pc_we`;
  - FETCH restarts; with `RV32_MC_PERF_EN`, both counters read 0.
